// File: rtl/ddr_rd_fifo_reader_if.sv
// ddr_rd_fifo_reader_if: FIFO read port and RGB565 pixel stream between the reader and its neighbours
interface ddr_rd_fifo_reader_if #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_PIX_WIDTH  = 16
);
  logic                    fifo_rd_en;
  logic [c_DATA_WIDTH-1:0] fifo_rd_data;
  logic                    fifo_rd_empty;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [c_PIX_WIDTH-1:0]  pix_data;
  logic                    pix_sof;
  logic                    pix_eol;
  logic                    pix_eof;
  modport master (
    output fifo_rd_en, input fifo_rd_data, input fifo_rd_empty,
    output pix_valid, input pix_ready, output pix_data, output pix_sof, output pix_eol, output pix_eof
  );
  modport slave (
    input fifo_rd_en, output fifo_rd_data, output fifo_rd_empty,
    input pix_valid, output pix_ready, input pix_data, input pix_sof, input pix_eol, input pix_eof
  );
endinterface

// File: rtl/ddr_rd_fifo_reader.sv
// ddr_rd_fifo_reader: reads one frame of 32-bit FIFO words and unpacks them into a framed RGB565 pixel stream
module ddr_rd_fifo_reader #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_PIX_WIDTH  = 16,
  parameter int c_H_ACTIVE   = 1280,
  parameter int c_V_ACTIVE   = 720
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst,
  input  logic                        frame_start,
  ddr_rd_fifo_reader_if.master        bus,
  output logic                        frame_done,
  output logic                        underflow,
  output logic                        busy
);
  localparam int c_WORDS = c_H_ACTIVE * c_V_ACTIVE / 2;
  localparam int c_XW    = $clog2(c_H_ACTIVE);
  localparam int c_YW    = $clog2(c_V_ACTIVE);
  localparam int c_RW    = $clog2(c_WORDS + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                  state_q, state_d;
  logic [c_XW-1:0]         x_cnt_q, x_cnt_d;
  logic [c_YW-1:0]         y_cnt_q, y_cnt_d;
  logic [c_RW-1:0]         req_q, req_d;
  logic [c_DATA_WIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
  logic [1:0]              q_cnt_q, q_cnt_d, wr_idx;
  logic                    half_q, half_d;
  logic                    infl_q, infl_d;
  logic                    started_q, started_d;
  logic                    underflow_q, underflow_d;
  logic                    frame_done_q, frame_done_d;
  logic                    run, eol, eof, accept, pop, push, rd_en;
  always_comb begin
    run = state_q == RUN;
    eol = x_cnt_q == c_XW'(c_H_ACTIVE - 1);
    eof = eol && y_cnt_q == c_YW'(c_V_ACTIVE - 1);
    bus.pix_valid = run && q_cnt_q != 2'd0;
    bus.pix_data  = !bus.pix_valid ? '0 : half_q ? q0_q[c_DATA_WIDTH-1 -: c_PIX_WIDTH] : q0_q[c_PIX_WIDTH-1:0];
    bus.pix_sof   = bus.pix_valid && x_cnt_q == '0 && y_cnt_q == '0;
    bus.pix_eol   = bus.pix_valid && eol;
    bus.pix_eof   = bus.pix_valid && eof;
    accept = bus.pix_valid && bus.pix_ready;
    pop    = accept && half_q;
    // A word returning in the restart cycle belongs to the old frame; the restart cycle issues no read
    push   = infl_q && !frame_start;
    rd_en  = run && !frame_start && !bus.fifo_rd_empty &&
             ({1'b0, q_cnt_q} + {2'b00, infl_q} < 3'd2) && req_q < c_RW'(c_WORDS);
    bus.fifo_rd_en = rd_en;
    wr_idx   = q_cnt_q - {1'b0, pop};
    q0_d     = push && wr_idx == 2'd0 ? bus.fifo_rd_data : pop ? q1_q : q0_q;
    q1_d     = push && wr_idx == 2'd1 ? bus.fifo_rd_data : q1_q;
    q_cnt_d  = frame_start ? 2'd0 : q_cnt_q + {1'b0, push} - {1'b0, pop};
    infl_d   = rd_en;
    req_d    = frame_start ? '0 : req_q + c_RW'(rd_en);
    half_d   = !frame_start && (half_q ^ accept);
    x_cnt_d  = frame_start ? '0 : !accept ? x_cnt_q : eol ? '0 : x_cnt_q + c_XW'(1);
    y_cnt_d  = frame_start ? '0 : !(accept && eol) ? y_cnt_q : eof ? '0 : y_cnt_q + c_YW'(1);
    started_d    = !frame_start && (started_q || accept);
    underflow_d  = !frame_start && (underflow_q || (run && bus.pix_ready && !bus.pix_valid && started_q));
    frame_done_d = accept && eof;
    state_d      = frame_start ? RUN : accept && eof ? IDLE : state_q;
    busy       = run;
    underflow  = underflow_q;
    frame_done = frame_done_q;
  end
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= IDLE;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      req_q        <= '0;
      q0_q         <= '0;
      q1_q         <= '0;
      q_cnt_q      <= 2'd0;
      half_q       <= 1'b0;
      infl_q       <= 1'b0;
      started_q    <= 1'b0;
      underflow_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      req_q        <= req_d;
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      q_cnt_q      <= q_cnt_d;
      half_q       <= half_d;
      infl_q       <= infl_d;
      started_q    <= started_d;
      underflow_q  <= underflow_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_ddr_rd_fifo_reader.sv
// tb_ddr_rd_fifo_reader: directed scoreboard bench for the frame reader on a 4x2 frame
module tb_ddr_rd_fifo_reader;
  localparam int H = 4;
  localparam int V = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done, underflow, busy;
  ddr_rd_fifo_reader_if #(.c_DATA_WIDTH(32), .c_PIX_WIDTH(16)) bus ();
  ddr_rd_fifo_reader #(.c_DATA_WIDTH(32), .c_PIX_WIDTH(16), .c_H_ACTIVE(H), .c_V_ACTIVE(V)) dut (
    .rd_clk(clk), .rd_rst(rst), .frame_start(frame_start), .bus(bus),
    .frame_done(frame_done), .underflow(underflow), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [31:0] fifo[$];
  logic [18:0] exp_q[$];
  logic [18:0] held;
  int ppos, checks = 0, fails = 0, cyc = 0, t0;
  int hs_cnt, rd_cnt, first_hs, last_hs, fd_cyc;
  bit fd_seen, bp, stall_prev;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push_word(input logic [31:0] w, input bit scored);
    fifo.push_back(w);
    bus.fifo_rd_empty = 1'b0;
    if (scored) for (int k = 0; k < 2; k++) begin
      int x = ppos % H;
      int y = (ppos / H) % V;
      exp_q.push_back({k == 1 ? w[31:16] : w[15:0], x == 0 && y == 0, x == H - 1, x == H - 1 && y == V - 1});
      ppos++;
    end
  endtask
  task automatic tick();
    bit rd;
    logic [18:0] obs;
    logic [31:0] exp;
    @(negedge clk);
    rd  = bus.fifo_rd_en;
    obs = {bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_eof};
    if (rd) rd_cnt++;
    if (stall_prev && bus.pix_valid) chk("hold", {13'd0, obs}, {13'd0, held});
    stall_prev = bus.pix_valid && !bus.pix_ready;
    held = obs;
    if (bus.pix_valid && bus.pix_ready) begin
      if (hs_cnt == 0) first_hs = cyc;
      last_hs = cyc;
      hs_cnt++;
      exp = 'x;
      if (exp_q.size() != 0) exp = {13'd0, exp_q.pop_front()};
      chk("pixel", {13'd0, obs}, exp);
    end
    if (frame_done) begin
      fd_seen = 1'b1;
      fd_cyc = cyc;
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fifo.size() != 0) bus.fifo_rd_data = fifo.pop_front();
    bus.fifo_rd_empty = fifo.size() == 0;
    if (bp) bus.pix_ready = !bus.pix_ready;
  endtask
  task automatic clear_stats();
    hs_cnt = 0; rd_cnt = 0; fd_seen = 1'b0; first_hs = -1; last_hs = -1; fd_cyc = -1;
  endtask
  task automatic start_frame();
    frame_start = 1'b1;
    t0 = cyc;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && !fd_seen; i++) tick();
    chk("frame_done_seen", {31'd0, fd_seen}, 32'd1);
  endtask
  initial begin
    bus.pix_ready = 1'b1;
    bus.fifo_rd_empty = 1'b1;
    bus.fifo_rd_data = '0;
    bp = 1'b0;
    stall_prev = 1'b0;
    ppos = 0;
    clear_stats();
    for (int i = 0; i < 4; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    repeat (3) tick();
    chk("rst_valid", {31'd0, bus.pix_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_underflow", {31'd0, underflow}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    // small frame, full rate
    repeat (2) tick();
    chk("idle_no_reads", rd_cnt, 0);
    clear_stats();
    start_frame();
    run_to_done(40);
    chk("first_pixel_cycle", first_hs, t0 + 3);
    chk("last_pixel_cycle", last_hs, t0 + 10);
    chk("frame_done_cycle", fd_cyc, t0 + 11);
    chk("pixels_small", hs_cnt, 8);
    chk("reads_small", rd_cnt, 4);
    chk("scoreboard_small", exp_q.size(), 0);
    // backpressure
    ppos = 0;
    for (int i = 0; i < 4; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    bp = 1'b1;
    bus.pix_ready = 1'b1;
    clear_stats();
    start_frame();
    run_to_done(60);
    bp = 1'b0;
    bus.pix_ready = 1'b1;
    chk("pixels_bp", hs_cnt, 8);
    chk("scoreboard_bp", exp_q.size(), 0);
    // underflow
    ppos = 0;
    for (int i = 0; i < 2; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    clear_stats();
    start_frame();
    repeat (10) tick();
    chk("uf_pixels", hs_cnt, 4);
    chk("uf_flag", {31'd0, underflow}, 32'd1);
    chk("uf_valid", {31'd0, bus.pix_valid}, 32'd0);
    chk("uf_busy", {31'd0, busy}, 32'd1);
    for (int i = 2; i < 4; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    run_to_done(40);
    chk("uf_pixels_all", hs_cnt, 8);
    chk("uf_sticky", {31'd0, underflow}, 32'd1);
    chk("scoreboard_uf", exp_q.size(), 0);
    // over-read guard
    ppos = 0;
    for (int i = 0; i < 6; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, i < 4);
    clear_stats();
    start_frame();
    chk("uf_cleared", {31'd0, underflow}, 32'd0);
    run_to_done(40);
    repeat (4) tick();
    chk("guard_reads", rd_cnt, 4);
    chk("guard_left", fifo.size(), 2);
    chk("scoreboard_guard", exp_q.size(), 0);
    fifo.delete();
    bus.fifo_rd_empty = 1'b1;
    // mid-frame restart
    ppos = 0;
    for (int i = 0; i < 4; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    clear_stats();
    start_frame();
    for (int i = 0; i < 20 && hs_cnt < 3; i++) tick();
    chk("restart_pixels_before", hs_cnt, 3);
    bus.pix_ready = 1'b0;
    fifo.delete();
    exp_q.delete();
    ppos = 0;
    for (int i = 0; i < 4; i++) push_word({16'(2 * i + 18), 16'(2 * i + 17)}, 1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    bus.pix_ready = 1'b1;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_underflow", {31'd0, underflow}, 32'd0);
    clear_stats();
    run_to_done(40);
    chk("restart_pixels", hs_cnt, 8);
    chk("scoreboard_restart", exp_q.size(), 0);
    // asynchronous reset mid-frame
    ppos = 0;
    for (int i = 0; i < 4; i++) push_word({16'(2 * i + 2), 16'(2 * i + 1)}, 1'b1);
    clear_stats();
    start_frame();
    for (int i = 0; i < 20 && hs_cnt < 4; i++) tick();
    chk("arst_pixels_before", hs_cnt, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.pix_valid}, 32'd0);
    chk("arst_data", {16'd0, bus.pix_data}, 32'd0);
    chk("arst_flags", {29'd0, bus.pix_sof, bus.pix_eol, bus.pix_eof}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("arst_done_uf", {30'd0, frame_done, underflow}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    clear_stats();
    repeat (5) tick();
    chk("arst_no_reads", rd_cnt, 0);
    chk("arst_idle", {31'd0, busy}, 32'd0);
    chk("arst_no_pixels", hs_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ddr_rd_fifo_reader.md
# ddr_rd_fifo_reader

Pulls 32-bit words from the read-side port of the DDR read FIFO and unpacks each word into two 16-bit RGB565 pixels on a valid/ready pixel stream. The stream carries start-of-frame and end-of-line/end-of-frame markers. The block sits between the read FIFO and the video output pipeline, in the FIFO's read clock domain. It reads exactly one frame's worth of words per `frame_start`, and flags underflow when the FIFO cannot keep up.

## Interface
Parameters:
- `c_DATA_WIDTH`, 32: FIFO word width; fixed at 2 × `c_PIX_WIDTH`.
- `c_PIX_WIDTH`, 16: pixel width.
- `c_H_ACTIVE`, 1280: pixels per line; must be even.
- `c_V_ACTIVE`, 720: lines per frame.

Ports:
- `rd_clk` in 1: sole clock. One clock; reset is asynchronous and active-high.
- `rd_rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: single-cycle pulse that starts, or restarts, a frame.
- `fifo_rd_en` out 1: FIFO read enable. Read data is valid the cycle after `fifo_rd_en` is asserted.
- `fifo_rd_data` in 32: FIFO read data.
- `fifo_rd_empty` in 1: FIFO empty flag.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: downstream accepts the pixel.
- `pix_data` out 16: pixel data.
- `pix_sof` out 1: qualifies the first pixel of the frame.
- `pix_eol` out 1: qualifies the last pixel of a line.
- `pix_eof` out 1: qualifies the last pixel of the frame.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `underflow` out 1: sticky error flag.
- `busy` out 1: high while the state is RUN.

## Operation
State machine:
- **IDLE**
  - `frame_start` → RUN.
  - Clears the counters, the word queue and `underflow`.
- **RUN**
  - Last pixel accepted (`pix_valid & pix_ready & pix_eof`) → IDLE, with `frame_done` pulsed in the following cycle.
  - `frame_start` while in RUN restarts the frame:
    - counters cleared;
    - word queue flushed;
    - any word returning that cycle or the next from an already-issued read is discarded;
    - state stays RUN;
    - `underflow` cleared.

Word queue and FIFO reads:
- Internal 2-entry word queue; the head word is output as pixels.
- `fifo_rd_en` = RUN & !`fifo_rd_empty` & (queue occupancy + reads in flight < 2) & (words requested < `c_H_ACTIVE`·`c_V_ACTIVE`/2).
- The block never requests a word belonging to the next frame.

Pixel unpacking:
- Each word yields pixel 0 = `[15:0]` first, then pixel 1 = `[31:16]`.
- A half-select bit toggles on each accepted pixel; the word is popped after pixel 1 is accepted.
- `pix_valid` = RUN & queue not empty.
- `pix_data`, `pix_sof`, `pix_eol` and `pix_eof` hold stable while `pix_valid & !pix_ready`.

Counters:
- `x_cnt` runs 0..`c_H_ACTIVE`-1; `y_cnt` runs 0..`c_V_ACTIVE`-1. Both are $clog2-sized and advance on each accepted pixel.
- `x_cnt` wraps to 0 on EOL, and `y_cnt` increments at the same time.
- `pix_sof` = (`x_cnt`==0 & `y_cnt`==0).
- `pix_eol` = (`x_cnt`==`c_H_ACTIVE`-1).
- `pix_eof` = `pix_eol` & (`y_cnt`==`c_V_ACTIVE`-1).

Underflow:
- Set when RUN & `pix_ready` & !`pix_valid`, but only after the first pixel of the frame has been accepted.
- Once set, it stays high until the next `frame_start` or `rd_rst`.
- Data is not dropped; the stream simply stalls.

Reset:
- All outputs are 0, the state is IDLE, the queue is empty and the counters are 0.
- Reset asserted mid-frame aborts immediately. Reads already issued are not waited for.

## Timing
Pipeline from `frame_start`:
- `frame_start` in cycle T → `busy` and first possible `fifo_rd_en` in T+1.
- Word registered at the end of T+2; `pix_valid` with `pix_sof` in T+3, provided the FIFO was non-empty at T+1.

Throughput and queue behaviour:
- Sustained rate is 1 pixel per cycle with `pix_ready` held high and the FIFO non-empty: one FIFO read every 2 cycles.
- A word returning while the queue is full cannot happen, because of the occupancy + in-flight rule.
- Simultaneous pop and returning word in the same cycle: occupancy is unchanged.

Frame end and back-to-back frames:
- `frame_done` is asserted in the cycle after the EOF handshake. `busy` falls in that same cycle.
- `frame_start` coinciding with the EOF handshake is treated as a new frame, and `frame_done` still pulses.

## Test plan
- **Small frame**: `c_H_ACTIVE`=4, `c_V_ACTIVE`=2; FIFO preloaded with 0x00020001, 0x00040003, 0x00060005, 0x00080007; `pix_ready`=1.
  - `pix_data` sequence 1..8 over 8 consecutive cycles starting T+3.
  - `pix_sof` on pixel 1; `pix_eol` on pixels 4 and 8; `pix_eof` on pixel 8.
  - `frame_done` the cycle after pixel 8.
  - Exactly 4 `fifo_rd_en` pulses.
- **Backpressure**: same frame, `pix_ready` toggled 1,0,1,0.
  - `pix_data` and flags hold while not ready.
  - Same 8-value order; no duplicates or drops.
- **Underflow**: FIFO holds 2 words only, `pix_ready`=1.
  - After pixel 4, `underflow`=1 and `pix_valid`=0.
  - Push 2 more words: pixels 5..8 are delivered, `underflow` stays 1 until the next `frame_start`.
- **Over-read guard**: FIFO holds 6 words with frame = 4 words.
  - Exactly 4 reads issued; 2 words remain in the FIFO after `frame_done`.
- **Mid-frame restart**: `frame_start` after pixel 3 is accepted.
  - Queue flushed; the next pixel carries `pix_sof` with `x_cnt`=0.
  - `underflow` cleared; `busy` stays 1.
- **Async reset mid-frame**: assert `rd_rst` between clock edges during pixel 5.
  - All outputs 0 immediately.
  - After release, no reads until `frame_start`.
